// File: rtl/prn_pkg.sv
// Shared definitions for the PRN sync checker: state encoding, default sizes
// and the zero-means-one threshold helper.
package prn_pkg;

  localparam int LFSR_LENGTH_DEF = 14;
  localparam int ERR_WIDTH_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCK   = 2'd3
  } prn_state_e;

  // A threshold of 0 would never be reached by a post-increment compare.
  function automatic logic [7:0] thr_eff(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/prn_lfsr_step.sv
// One step of the checker LFSR: tap-mask prediction and shifted next state.
// In flywheel mode the register feeds back its own prediction.
module prn_lfsr_step
  import prn_pkg::*;
#(
  parameter int LFSR_LENGTH = LFSR_LENGTH_DEF
) (
  input  logic [LFSR_LENGTH-1:0] i_lfsr,
  input  logic [LFSR_LENGTH-1:0] i_poly,
  input  logic                   i_chip,
  input  logic                   i_flywheel,
  output logic                   o_pred,
  output logic [LFSR_LENGTH-1:0] o_next
);

  logic w_pred;
  logic w_bit;

  assign w_pred = ^(i_lfsr & i_poly);
  assign w_bit  = i_flywheel ? w_pred : i_chip;
  assign o_pred = w_pred;
  assign o_next = {i_lfsr[LFSR_LENGTH-2:0], w_bit};

endmodule

// File: rtl/prn_sync_checker.sv
// PRN sync checker: fills an LFSR from received chips, verifies the prediction,
// then flywheels in LOCK while counting chips and errors.
module prn_sync_checker
  import prn_pkg::*;
#(
  parameter int LFSR_LENGTH = LFSR_LENGTH_DEF,
  parameter int ERR_WIDTH   = ERR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [LFSR_LENGTH-1:0] poly,
  input  logic [7:0]             sync_threshold,
  input  logic [7:0]             loss_threshold,
  input  logic                   chip_valid,
  input  logic                   chip_in,
  input  logic                   clear_stats,
  output logic [1:0]             fsm_state_o,
  output logic                   locked,
  output logic                   lock_lost,
  output logic [LFSR_LENGTH-1:0] lfsr_state_o,
  output logic [31:0]            chip_count_o,
  output logic [ERR_WIDTH-1:0]   error_count_o
);

  localparam int FCW = $clog2(LFSR_LENGTH + 1);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(LFSR_LENGTH - 1);

  prn_state_e             r_state;
  logic [LFSR_LENGTH-1:0] r_lfsr;
  logic [FCW-1:0]         r_fill_cnt;
  logic [7:0]             r_match_cnt;
  logic [7:0]             r_cons_err;
  logic [31:0]            r_chip_cnt;
  logic [ERR_WIDTH-1:0]   r_err_cnt;
  logic                   r_locked;
  logic                   r_lock_lost;

  logic                   w_pred;
  logic [LFSR_LENGTH-1:0] w_next;
  logic                   w_match;
  logic [7:0]             w_sync_thr;
  logic [7:0]             w_loss_thr;
  logic                   w_sync_hit;
  logic                   w_loss_hit;
  logic                   w_lock_chip;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  prn_lfsr_step #(.LFSR_LENGTH(LFSR_LENGTH)) u_step (
    .i_lfsr     (r_lfsr),
    .i_poly     (poly),
    .i_chip     (chip_in),
    .i_flywheel (r_state == ST_LOCK),
    .o_pred     (w_pred),
    .o_next     (w_next)
  );

  assign w_match     = (chip_in == w_pred);
  assign w_sync_thr  = thr_eff(sync_threshold);
  assign w_loss_thr  = thr_eff(loss_threshold);
  assign w_sync_hit  = ({1'b0, r_match_cnt} + 9'd1) >= {1'b0, w_sync_thr};
  assign w_loss_hit  = ({1'b0, r_cons_err} + 9'd1) >= {1'b0, w_loss_thr};
  assign w_lock_chip = enable && (r_state == ST_LOCK) && chip_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_cons_err  <= '0;
      r_chip_cnt  <= '0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      if (!enable) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
          end
          ST_FILL: if (chip_valid) begin
            r_lfsr <= w_next;
            if (r_fill_cnt == FILL_LAST) begin
              r_fill_cnt <= '0;
              // An all-zero window can never predict anything useful.
              if (w_next != '0) begin
                r_state     <= ST_VERIFY;
                r_match_cnt <= '0;
              end
            end else begin
              r_fill_cnt <= r_fill_cnt + FCW'(1);
            end
          end
          ST_VERIFY: if (chip_valid) begin
            r_lfsr <= w_next;
            if (w_match) begin
              r_match_cnt <= r_match_cnt + 8'd1;
              if (w_sync_hit) begin
                r_state    <= ST_LOCK;
                r_locked   <= 1'b1;
                r_cons_err <= '0;
              end
            end else begin
              // The offending chip is already the first chip of a new fill.
              r_state    <= ST_FILL;
              r_fill_cnt <= FCW'(1);
            end
          end
          ST_LOCK: if (chip_valid) begin
            r_lfsr <= w_next;
            if (w_match) begin
              r_cons_err <= '0;
            end else if (w_loss_hit) begin
              r_state     <= ST_FILL;
              r_fill_cnt  <= '0;
              r_cons_err  <= '0;
              r_locked    <= 1'b0;
              r_lock_lost <= 1'b1;
            end else begin
              r_cons_err <= r_cons_err + 8'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (clear_stats) begin
        r_chip_cnt <= '0;
        r_err_cnt  <= '0;
      end else if (w_lock_chip) begin
        r_chip_cnt <= r_chip_cnt + 32'd1;
        if (!w_match) r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  assign fsm_state_o   = r_state;
  assign locked        = r_locked;
  assign lock_lost     = r_lock_lost;
  assign lfsr_state_o  = r_lfsr;
  assign chip_count_o  = r_chip_cnt;
  assign error_count_o = r_err_cnt;

endmodule

// File: tb/tb_prn_sync_checker.sv
// Scoreboard bench for prn_sync_checker: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_prn_sync_checker;

  localparam int L = 14;
  localparam int EW = 16;
  localparam int M_ST = 1, M_LK = 2, M_LL = 4, M_ERR = 8, M_CC = 16, M_LF = 32;
  localparam int M_ALL = 63;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [L-1:0]  poly;
  logic [7:0]    sync_threshold;
  logic [7:0]    loss_threshold;
  logic          chip_valid;
  logic          chip_in;
  logic          clear_stats;
  logic [1:0]    fsm_state_o;
  logic          locked;
  logic          lock_lost;
  logic [L-1:0]  lfsr_state_o;
  logic [31:0]   chip_count_o;
  logic [EW-1:0] error_count_o;

  prn_sync_checker #(.LFSR_LENGTH(L), .ERR_WIDTH(EW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .poly           (poly),
    .sync_threshold (sync_threshold),
    .loss_threshold (loss_threshold),
    .chip_valid     (chip_valid),
    .chip_in        (chip_in),
    .clear_stats    (clear_stats),
    .fsm_state_o    (fsm_state_o),
    .locked         (locked),
    .lock_lost      (lock_lost),
    .lfsr_state_o   (lfsr_state_o),
    .chip_count_o   (chip_count_o),
    .error_count_o  (error_count_o)
  );

  typedef struct {
    int          cyc;
    string       nm;
    int          mask;
    logic [1:0]  st;
    logic        lk;
    logic        ll;
    logic [15:0] err;
    logic [31:0] cc;
    logic [13:0] lf;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [L-1:0] mlfsr;
  logic [L-1:0] seed;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic mpred(input logic [L-1:0] s);
    return ^(s & 14'h2801);
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s actual=%0h required=%0h (cycle %0d)", nm, fld, act, req, cyc);
    end
  endtask

  // Monitor: compare every expectation targeted at the cycle just completed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        chk(e.nm, "stale", 32'(cyc), 32'(e.cyc));
      end else begin
        if ((e.mask & M_ST)  != 0) chk(e.nm, "state",   32'(fsm_state_o),   32'(e.st));
        if ((e.mask & M_LK)  != 0) chk(e.nm, "locked",  32'(locked),        32'(e.lk));
        if ((e.mask & M_LL)  != 0) chk(e.nm, "lostpls", 32'(lock_lost),     32'(e.ll));
        if ((e.mask & M_ERR) != 0) chk(e.nm, "errcnt",  32'(error_count_o), 32'(e.err));
        if ((e.mask & M_CC)  != 0) chk(e.nm, "chipcnt", chip_count_o,       e.cc);
        if ((e.mask & M_LF)  != 0) chk(e.nm, "lfsr",    32'(lfsr_state_o),  32'(e.lf));
      end
    end
  end

  task automatic expect_out(input string nm, input int mask, input logic [1:0] st, input logic lk,
                            input logic ll, input logic [15:0] err, input logic [31:0] cc);
    exp_t e;
    e.cyc = cyc + 1; e.nm = nm; e.mask = mask; e.st = st; e.lk = lk;
    e.ll = ll; e.err = err; e.cc = cc; e.lf = mlfsr;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    chip_valid = 1'b0;
    chip_in    = 1'b0;
  endtask

  task automatic set_raw(input logic b);
    chip_valid = 1'b1;
    chip_in    = b;
    mlfsr      = {mlfsr[L-2:0], b};
  endtask

  // inv flips the sent chip; inject puts the flipped chip into the model too.
  task automatic set_gen(input logic inv, input logic inject);
    logic t;
    t = mpred(mlfsr);
    chip_valid = 1'b1;
    chip_in    = t ^ inv;
    mlfsr      = {mlfsr[L-2:0], inject ? (t ^ inv) : t};
  endtask

  task automatic send_seed();
    for (int i = L - 1; i >= 0; i--) begin
      set_raw(seed[i]);
      if (i == 0) expect_out("fill_done", M_ST | M_LK | M_LF, 2'd2, 1'b0, 1'b0, 16'd0, 32'd0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; poly = 14'h2801; sync_threshold = 8'd16; loss_threshold = 8'd4;
    chip_valid = 1'b0; chip_in = 1'b0; clear_stats = 1'b0;
    mlfsr = '0; seed = 14'h2B3C;
    tick();
    expect_out("reset", M_ALL, 2'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();
    rst = 1'b0; enable = 1'b1;
    expect_out("idle_to_fill", M_ST | M_LK, 2'd1, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();

    // Acquisition: 14 fill chips then 16 verified chips.
    send_seed();
    for (int i = 1; i <= 16; i++) begin
      set_gen(1'b0, 1'b0);
      if (i == 15) expect_out("verify15", M_ST | M_LK, 2'd2, 1'b0, 1'b0, 16'd0, 32'd0);
      if (i == 16) expect_out("lock30", M_ALL, 2'd3, 1'b1, 1'b0, 16'd0, 32'd0);
      tick();
    end

    // Flywheel errors and loss of lock.
    for (int i = 1; i <= 5; i++) begin
      set_gen(1'b0, 1'b0);
      if (i == 5) expect_out("lock_cnt5", M_ALL, 2'd3, 1'b1, 1'b0, 16'd0, 32'd5);
      tick();
    end
    set_gen(1'b1, 1'b0);
    expect_out("one_err", M_ALL, 2'd3, 1'b1, 1'b0, 16'd1, 32'd6);
    tick();
    for (int i = 1; i <= 2; i++) begin set_gen(1'b0, 1'b0); tick(); end
    for (int i = 1; i <= 4; i++) begin
      set_gen(1'b1, 1'b0);
      if (i < 4) expect_out("err_run", M_ST | M_LK | M_LL | M_ERR, 2'd3, 1'b1, 1'b0, 16'(1 + i), 32'd0);
      else       expect_out("loss", M_ALL, 2'd1, 1'b0, 1'b1, 16'd5, 32'd12);
      tick();
    end
    expect_out("loss_pulse_end", M_ALL, 2'd1, 1'b0, 1'b0, 16'd5, 32'd12);
    tick();

    // Mismatch on the 5th verify chip restarts fill with one chip counted.
    for (int i = 1; i <= 14; i++) begin set_gen(1'b0, 1'b0); tick(); end
    for (int i = 1; i <= 4; i++) begin set_gen(1'b0, 1'b0); tick(); end
    set_gen(1'b1, 1'b1);
    expect_out("verify_miss", M_ALL, 2'd1, 1'b0, 1'b0, 16'd5, 32'd12);
    tick();
    for (int i = 1; i <= 13; i++) begin
      set_gen(1'b0, 1'b0);
      if (i == 12) expect_out("refill12", M_ST, 2'd1, 1'b0, 1'b0, 16'd0, 32'd0);
      if (i == 13) expect_out("refill13", M_ST | M_LF, 2'd2, 1'b0, 1'b0, 16'd0, 32'd0);
      tick();
    end
    for (int i = 1; i <= 16; i++) begin
      set_gen(1'b0, 1'b0);
      if (i == 15) expect_out("reverify15", M_ST | M_LK, 2'd2, 1'b0, 1'b0, 16'd0, 32'd0);
      if (i == 16) expect_out("relock", M_ALL, 2'd3, 1'b1, 1'b0, 16'd5, 32'd12);
      tick();
    end

    // clear_stats, alone and against a same-edge increment.
    clear_stats = 1'b1;
    expect_out("clear_idle", M_ERR | M_CC, 2'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();
    clear_stats = 1'b0;
    for (int i = 1; i <= 3; i++) begin set_gen(1'b0, 1'b0); tick(); end
    set_gen(1'b1, 1'b0); clear_stats = 1'b1;
    expect_out("clear_vs_inc", M_ALL, 2'd3, 1'b1, 1'b0, 16'd0, 32'd0);
    tick();
    clear_stats = 1'b0;
    set_gen(1'b0, 1'b0);
    expect_out("count_after_clear", M_CC | M_ERR, 2'd0, 1'b0, 1'b0, 16'd0, 32'd1);
    tick();

    // enable drop, then reacquire with chip_valid on alternate cycles.
    enable = 1'b0;
    expect_out("disable", M_ALL, 2'd0, 1'b0, 1'b0, 16'd0, 32'd1);
    tick();
    enable = 1'b1;
    expect_out("reenable", M_ST | M_LF, 2'd1, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();
    begin
      int k;
      k = 0;
      for (int c = 1; c <= 59; c++) begin
        if (c % 2 == 1) begin set_gen(1'b0, 1'b0); k++; end
        expect_out("toggle", M_ST | M_LK | M_LF, (k < 14) ? 2'd1 : (k < 30) ? 2'd2 : 2'd3,
                   k >= 30, 1'b0, 16'd0, 32'd0);
        tick();
      end
    end

    // Reset in LOCK with 50 chips counted.
    for (int i = 1; i <= 49; i++) begin
      set_gen(1'b0, 1'b0);
      if (i == 49) expect_out("cc50", M_ST | M_CC, 2'd3, 1'b1, 1'b0, 16'd0, 32'd50);
      tick();
    end
    rst = 1'b1; enable = 1'b0; set_gen(1'b1, 1'b0); mlfsr = '0;
    expect_out("rst_in_lock", M_ALL, 2'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();
    rst = 1'b0;
    expect_out("after_rst", M_ALL, 2'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();

    // All-zero stream never leaves FILL.
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 100; i++) begin
      set_raw(1'b0);
      expect_out("zeros", M_ST | M_LK | M_LF, 2'd1, 1'b0, 1'b0, 16'd0, 32'd0);
      tick();
    end

    // Zero thresholds behave as one.
    enable = 1'b0; tick();
    enable = 1'b1; sync_threshold = 8'd0; loss_threshold = 8'd0; tick();
    send_seed();
    set_gen(1'b0, 1'b0);
    expect_out("thr0_lock", M_ALL, 2'd3, 1'b1, 1'b0, 16'd0, 32'd0);
    tick();
    set_gen(1'b1, 1'b0);
    expect_out("thr0_loss", M_ALL, 2'd1, 1'b0, 1'b1, 16'd1, 32'd1);
    tick();

    repeat (3) tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
